// File: rtl/conv_intrm_pipe_if.sv
// Beat handshake bundle for conv_intrm_pipe: upstream valid/ready/data, downstream
// valid/ready/data and the partial-group beat count.
interface conv_intrm_pipe_if #(
    parameter int NUM_CH       = 5,
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 64,
    parameter int CNT_W        = 3
);
    logic                                     in_valid_i;
    logic                                     in_ready_o;
    logic [NUM_CH-1:0][INPUT_WIDTH-1:0]       in_data_i;
    logic                                     out_valid_o;
    logic                                     out_ready_i;
    logic [NUM_CH-1:0][OUTPUT_WIDTH-1:0]      out_data_o;
    logic [CNT_W-1:0]                         acc_cnt_o;

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, acc_cnt_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, acc_cnt_o
    );
endinterface

// File: rtl/conv_intrm_pipe.sv
// Elastic multi-channel pipe for conv intermediates: width-extends each channel,
// optionally sums ACC_LEN beats per channel, then shifts through DEPTH valid/ready stages.
module conv_intrm_lane #(
    parameter int IW     = 32,
    parameter int OW     = 64,
    parameter int SIGNED = 1
) (
    input  logic [IW-1:0] din,
    input  logic [OW-1:0] acc,
    input  logic          first,
    output logic [OW-1:0] ext,
    output logic [OW-1:0] sum
);
    always_comb begin
        ext = (SIGNED != 0) ? OW'($signed(din)) : OW'(din);
        sum = first ? ext : acc + ext;
    end
endmodule

module conv_intrm_pipe #(
    parameter int NUM_CH       = 5,
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 2*INPUT_WIDTH,
    parameter int DEPTH        = 2,
    parameter int SIGNED       = 1,
    parameter int ACC_LEN      = 5,
    parameter int CNT_W        = $clog2(ACC_LEN+1)
) (
    input  logic             intrm_pipe_clk,
    input  logic             intrm_pipe_rst_b,
    input  logic             intrm_pipe_flush_i,
    input  logic             intrm_pipe_acc_mode_i,
    conv_intrm_pipe_if.slave bus
);
    typedef logic [NUM_CH-1:0][OUTPUT_WIDTH-1:0] beat_t;

    logic [DEPTH-1:0]         vld;
    logic [DEPTH-1:0]         adv;
    beat_t [DEPTH-1:0]        d;
    beat_t                    acc_q;
    beat_t                    ext_w;
    beat_t                    sum_w;
    logic [CNT_W-1:0]         cnt;
    logic                     mode_q;
    logic                     mode_eff;
    logic                     first;
    logic                     last;
    logic                     take;
    logic                     load0;

    // Ready ripples back combinationally so a full pipe still moves one beat per cycle.
    always_comb begin
        adv          = '0;
        adv[DEPTH-1] = bus.out_ready_i | ~vld[DEPTH-1];
        for (int k = DEPTH-2; k >= 0; k--) begin
            adv[k] = adv[k+1] | ~vld[k];
        end
    end

    // Mode is only sampled on the opening beat of a group.
    assign first    = (cnt == '0);
    assign last     = (cnt == CNT_W'(ACC_LEN-1));
    assign mode_eff = first ? intrm_pipe_acc_mode_i : mode_q;

    assign bus.in_ready_o  = adv[0] & ~intrm_pipe_flush_i;
    assign take            = bus.in_valid_i & bus.in_ready_o;
    assign load0           = take & (~mode_eff | last);
    assign bus.out_valid_o = vld[DEPTH-1];
    assign bus.out_data_o  = d[DEPTH-1];
    assign bus.acc_cnt_o   = cnt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        conv_intrm_lane #(
            .IW     (INPUT_WIDTH),
            .OW     (OUTPUT_WIDTH),
            .SIGNED (SIGNED)
        ) u_lane (
            .din   (bus.in_data_i[c]),
            .acc   (acc_q[c]),
            .first (first),
            .ext   (ext_w[c]),
            .sum   (sum_w[c])
        );
    end

    always_ff @(posedge intrm_pipe_clk) begin
        if (!intrm_pipe_rst_b) begin
            vld    <= '0;
            d      <= '0;
            acc_q  <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
        end else if (intrm_pipe_flush_i) begin
            vld   <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else begin
            if (adv[0]) begin
                vld[0] <= load0;
                if (load0) d[0] <= mode_eff ? sum_w : ext_w;
            end
            // Partial sums stay here; only a completed group reaches d[0].
            if (take && mode_eff) begin
                acc_q <= sum_w;
                cnt   <= last ? '0 : cnt + CNT_W'(1);
            end
            if (take && first) mode_q <= intrm_pipe_acc_mode_i;
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) d[k] <= d[k-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_intrm_pipe.sv
// Self-checking bench: table-driven extension vectors, directed accumulate/flush/
// backpressure/reset sequences, and randomized traffic against a queue-based model.
module tb_conv_intrm_pipe;
    typedef logic [4:0][63:0] beat_t;
    typedef logic [4:0][31:0] in_t;

    typedef struct {
        logic [31:0] din;
        logic [63:0] exp_s;
        logic [63:0] exp_u;
    } ext_vec_t;

    logic clk;
    logic rst_b, rst2_b;
    logic flush, acc_mode, in_valid, out_ready;
    in_t  in_data;
    logic flush2, acc2_mode, in2_valid, out2_ready;
    logic [4:0][7:0] in2_data;

    int n_tot  = 0;
    int n_pass = 0;

    conv_intrm_pipe_if #(.NUM_CH(5), .INPUT_WIDTH(32), .OUTPUT_WIDTH(64), .CNT_W(3)) bus0 ();
    conv_intrm_pipe_if #(.NUM_CH(5), .INPUT_WIDTH(32), .OUTPUT_WIDTH(64), .CNT_W(3)) bus1 ();
    conv_intrm_pipe_if #(.NUM_CH(5), .INPUT_WIDTH(8),  .OUTPUT_WIDTH(8),  .CNT_W(2)) bus2 ();

    assign bus0.in_valid_i  = in_valid;
    assign bus0.in_data_i   = in_data;
    assign bus0.out_ready_i = out_ready;
    assign bus1.in_valid_i  = in_valid;
    assign bus1.in_data_i   = in_data;
    assign bus1.out_ready_i = out_ready;
    assign bus2.in_valid_i  = in2_valid;
    assign bus2.in_data_i   = in2_data;
    assign bus2.out_ready_i = out2_ready;

    conv_intrm_pipe #(.NUM_CH(5), .INPUT_WIDTH(32), .OUTPUT_WIDTH(64), .DEPTH(2),
                      .SIGNED(1), .ACC_LEN(5)) u0 (
        .intrm_pipe_clk(clk), .intrm_pipe_rst_b(rst_b), .intrm_pipe_flush_i(flush),
        .intrm_pipe_acc_mode_i(acc_mode), .bus(bus0));

    conv_intrm_pipe #(.NUM_CH(5), .INPUT_WIDTH(32), .OUTPUT_WIDTH(64), .DEPTH(2),
                      .SIGNED(0), .ACC_LEN(5)) u1 (
        .intrm_pipe_clk(clk), .intrm_pipe_rst_b(rst_b), .intrm_pipe_flush_i(flush),
        .intrm_pipe_acc_mode_i(acc_mode), .bus(bus1));

    conv_intrm_pipe #(.NUM_CH(5), .INPUT_WIDTH(8), .OUTPUT_WIDTH(8), .DEPTH(2),
                      .SIGNED(0), .ACC_LEN(2)) u2 (
        .intrm_pipe_clk(clk), .intrm_pipe_rst_b(rst2_b), .intrm_pipe_flush_i(flush2),
        .intrm_pipe_acc_mode_i(acc2_mode), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t sext(input in_t x);
        beat_t r;
        for (int c = 0; c < 5; c++) r[c] = {{32{x[c][31]}}, x[c]};
        return r;
    endfunction

    function automatic beat_t splat(input logic [63:0] v);
        beat_t r;
        for (int c = 0; c < 5; c++) r[c] = v;
        return r;
    endfunction

    // Reference model for u0: beats in flight as a queue, groups summed arithmetically.
    beat_t q[$];
    beat_t m_sum;
    int    m_cnt  = 0;
    logic  m_mode = 1'b0;

    always @(negedge clk) begin
        if (!rst_b) begin
            q.delete();
            m_cnt = 0;
        end else begin
            chk("model_acc_cnt", 320'(bus0.acc_cnt_o), 320'(m_cnt));
            if (flush) begin
                q.delete();
                m_cnt = 0;
            end else begin
                if (bus0.out_valid_o && out_ready) begin
                    if (q.size() == 0) chk("model_spurious_out", 320'(1), 320'(0));
                    else chk("model_out_data", bus0.out_data_o, q.pop_front());
                end
                if (in_valid && bus0.in_ready_o) begin
                    if (m_cnt == 0) m_mode = acc_mode;
                    if (!m_mode) q.push_back(sext(in_data));
                    else begin
                        for (int c = 0; c < 5; c++)
                            m_sum[c] = (m_cnt == 0) ? sext(in_data)[c] : m_sum[c] + sext(in_data)[c];
                        m_cnt++;
                        if (m_cnt == 5) begin
                            q.push_back(m_sum);
                            m_cnt = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        automatic ext_vec_t tbl[8];
        automatic int exp_cnt[5] = '{1, 2, 3, 4, 0};
        automatic int n_acc;
        automatic logic [63:0] got[$];

        tbl[0] = '{32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
        tbl[1] = '{32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000};
        tbl[2] = '{32'h7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF};
        tbl[3] = '{32'h0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
        tbl[4] = '{32'h0000_0001, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001};
        tbl[5] = '{32'h1234_5678, 64'h0000_0000_1234_5678, 64'h0000_0000_1234_5678};
        tbl[6] = '{32'hF000_0001, 64'hFFFF_FFFF_F000_0001, 64'h0000_0000_F000_0001};
        tbl[7] = '{32'h0001_0000, 64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000};

        rst_b = 0; rst2_b = 0; flush = 0; acc_mode = 0; in_valid = 0; out_ready = 0;
        in_data = '0; flush2 = 0; acc2_mode = 0; in2_valid = 0; out2_ready = 0; in2_data = '0;
        step(); step();
        rst_b = 1; rst2_b = 1;

        chk("rst_out_valid", 320'(bus0.out_valid_o), 320'(0));
        chk("rst_out_data", bus0.out_data_o, '0);
        chk("rst_acc_cnt", 320'(bus0.acc_cnt_o), 320'(0));
        chk("rst_in_ready", 320'(bus0.in_ready_o), 320'(1));
        chk("rst_u2_in_ready", 320'(bus2.in_ready_o), 320'(1));

        // Pass mode through the extension table; beat i visible one edge after its accept.
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            in_data = {5{tbl[i].din}};
            in_data[0] = 32'(i + 1);
            step();
            if (i >= 1) begin
                chk("pass_valid", 320'(bus0.out_valid_o), 320'(1));
                chk("pass_ch0", 320'(bus0.out_data_o[0]), 320'(i));
                chk("sext_ch3", 320'(bus0.out_data_o[3]), 320'(tbl[i-1].exp_s));
                chk("zext_ch3", 320'(bus1.out_data_o[3]), 320'(tbl[i-1].exp_u));
            end
        end
        in_valid = 0;
        step();
        chk("pass_last_ch0", 320'(bus0.out_data_o[0]), 320'(8));
        chk("sext_last_ch3", 320'(bus0.out_data_o[3]), 320'(tbl[7].exp_s));
        step();
        chk("pass_drained", 320'(bus0.out_valid_o), 320'(0));

        // Accumulate 1..5 on all channels.
        acc_mode = 1; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_data = {5{32'(i + 1)}};
            step();
            chk("acc_cnt_seq", 320'(bus0.acc_cnt_o), 320'(exp_cnt[i]));
            if (i < 4) chk("acc_no_partial_out", 320'(bus0.out_valid_o), 320'(0));
        end
        in_valid = 0;
        step();
        chk("acc_out_valid", 320'(bus0.out_valid_o), 320'(1));
        chk("acc_out_sum", bus0.out_data_o, splat(64'd15));
        step();

        // Backpressure in pass mode: only DEPTH beats fit.
        acc_mode = 0; out_ready = 0; in_valid = 1; n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = {5{32'(100 + i)}};
            if (bus0.in_ready_o) n_acc++;
            step();
        end
        chk("bp_accepted", 320'(n_acc), 320'(2));
        chk("bp_in_ready_low", 320'(bus0.in_ready_o), 320'(0));
        in_valid = 0; out_ready = 1;
        for (int j = 0; j < 4; j++) begin
            if (bus0.out_valid_o) got.push_back(bus0.out_data_o[0]);
            step();
        end
        chk("bp_drain_count", 320'(got.size()), 320'(2));
        if (got.size() == 2) begin
            chk("bp_drain_0", 320'(got[0]), 320'(100));
            chk("bp_drain_1", 320'(got[1]), 320'(101));
        end

        // Flush mid-group, then a group that toggles acc_mode at beat 2.
        acc_mode = 1; in_valid = 1; in_data = {5{32'd7}};
        for (int i = 0; i < 3; i++) step();
        chk("fl_partial_cnt", 320'(bus0.acc_cnt_o), 320'(3));
        flush = 1; in_data = {5{32'd99}};
        #1;
        chk("fl_in_ready_low", 320'(bus0.in_ready_o), 320'(0));
        step();
        flush = 0;
        chk("fl_cnt_cleared", 320'(bus0.acc_cnt_o), 320'(0));
        chk("fl_out_valid", 320'(bus0.out_valid_o), 320'(0));
        in_data = {5{32'd1}};
        for (int i = 0; i < 5; i++) begin
            acc_mode = (i == 0);
            step();
            chk("fl_acc_cnt_seq", 320'(bus0.acc_cnt_o), 320'(exp_cnt[i]));
        end
        in_valid = 0;
        step();
        chk("fl_out_valid_sum", 320'(bus0.out_valid_o), 320'(1));
        chk("fl_out_sum", bus0.out_data_o, splat(64'd5));
        step();

        // 8-bit wrap with ACC_LEN=2, then reset with a full pipe.
        acc2_mode = 1; out2_ready = 1; in2_valid = 1; in2_data = {5{8'd200}};
        step();
        chk("wrap_cnt1", 320'(bus2.acc_cnt_o), 320'(1));
        in2_data = {5{8'd100}};
        step();
        chk("wrap_cnt0", 320'(bus2.acc_cnt_o), 320'(0));
        in2_valid = 0;
        step();
        chk("wrap_valid", 320'(bus2.out_valid_o), 320'(1));
        chk("wrap_sum", 320'(bus2.out_data_o), 320'({5{8'd44}}));
        acc2_mode = 0; out2_ready = 0; in2_valid = 1; in2_data = {5{8'h11}};
        step(); step(); step();
        chk("full_valid", 320'(bus2.out_valid_o), 320'(1));
        chk("full_in_ready", 320'(bus2.in_ready_o), 320'(0));
        in2_valid = 0; rst2_b = 0;
        step();
        rst2_b = 1;
        chk("midrst_valid", 320'(bus2.out_valid_o), 320'(0));
        chk("midrst_data", 320'(bus2.out_data_o), 320'(0));
        chk("midrst_in_ready", 320'(bus2.in_ready_o), 320'(1));

        // Randomized traffic on u0, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) acc_mode = ~acc_mode;
            for (int c = 0; c < 5; c++)
                in_data[c] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
            step();
        end
        in_valid = 0; flush = 0; out_ready = 1;
        for (int i = 0; i < 6; i++) step();
        chk("rand_drain_empty", 320'(q.size()), 320'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
